led7_scan_controller: RTL

Time-multiplexes one shared led7_decoder across NUM_DIGITS common-cathode digits. It scans the digits in sequence and drives the decoder's enable and 4-bit binary inputs. It also drives a one-hot digit-select bus, with anti-ghost blanking between digits. New display data is written into a shadow register and applied only at frame boundaries, so a frame never shows a mix of old and new data.

---
 rtl/led7_scan_controller.sv | 131 +++++++++++++
 1 files changed

// File: rtl/led7_scan_controller.sv
// Multiplexes one shared 7-segment decoder across NUM_DIGITS digits, with per-slot blanking
// and frame-synchronous data update. Optional macro: LED7_LEADING_ZERO_BLANK_EN.
module led7_scan_controller #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 1000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_en,
   input  logic                    i_load,
   input  logic [4*NUM_DIGITS-1:0] i_data,
   output logic                    o_dec_en,
   output logic [3:0]              o_dec_binary,
   output logic [NUM_DIGITS-1:0]   o_digit_sel,
   output logic                    o_frame_done,
   output logic                    o_pending
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DW = 4 * NUM_DIGITS;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

   state_t                state, state_nxt;
   logic [CW-1:0]         cnt, cnt_nxt;
   logic [IW-1:0]         idx, idx_nxt;
   logic [DW-1:0]         disp, disp_nxt;
   logic [DW-1:0]         shadow, shadow_nxt;
   logic                  pending, pending_nxt;
   logic                  boundary, apply, show, suppress;
   logic [3:0]            binary_nxt;
   logic [NUM_DIGITS-1:0] sel_nxt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= IDLE;
         cnt          <= '0;
         idx          <= '0;
         disp         <= '0;
         shadow       <= '0;
         pending      <= 1'b0;
         o_dec_en     <= 1'b0;
         o_dec_binary <= 4'h0;
         o_digit_sel  <= '0;
         o_frame_done <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         idx          <= idx_nxt;
         disp         <= disp_nxt;
         shadow       <= shadow_nxt;
         pending      <= pending_nxt;
         o_dec_en     <= show;
         o_dec_binary <= binary_nxt;
         o_digit_sel  <= sel_nxt;
         o_frame_done <= boundary;
      end
   end

   assign o_pending = pending;

   // Slot counter runs 0..REFRESH_DIV-1 across BLANK then SHOW of one digit.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      boundary  = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            idx_nxt = '0;
            if (i_en) state_nxt = (BLANK_CYCLES > 0) ? BLANK : SHOW;
         end
         default: begin
            if (!i_en) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               idx_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               cnt_nxt   = '0;
               boundary  = (idx == IDX_LAST);
               idx_nxt   = boundary ? '0 : idx + 1'b1;
               state_nxt = (BLANK_CYCLES > 0) ? BLANK : SHOW;
            end else begin
               cnt_nxt   = cnt + 1'b1;
               state_nxt = (cnt_nxt < CNT_SHOW) ? BLANK : SHOW;
            end
         end
      endcase
   end

   // The display register only changes at a frame boundary or while dark, so a
   // load landing on the boundary edge is held back one full frame.
   always_comb begin
      apply       = pending && (boundary || state == IDLE);
      disp_nxt    = apply ? shadow : disp;
      shadow_nxt  = i_load ? i_data : shadow;
      pending_nxt = i_load | (pending & ~apply);
   end

`ifdef LED7_LEADING_ZERO_BLANK_EN
   logic [IW-1:0] msnz;
   always_comb begin
      msnz = '0;
      for (int d = 0; d < NUM_DIGITS; d++)
         if (disp_nxt[d*4 +: 4] != 4'h0) msnz = IW'(d);
      suppress = (idx_nxt > msnz);
   end
`else
   assign suppress = 1'b0;
`endif

   // Outputs are computed from next-cycle values so the registered outputs match the state.
   always_comb begin
      show       = (state_nxt == SHOW) && !suppress;
      binary_nxt = 4'h0;
      sel_nxt    = '0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (idx_nxt == IW'(d)) begin
            if (state_nxt != IDLE) binary_nxt = disp_nxt[d*4 +: 4];
            sel_nxt[d] = show;
         end
      end
   end

endmodule
